// File: rtl/tc_sram_pkg.sv
// Shared sizing, types and FSM encoding for the A-operand SRAM read path.
// Imported by the read sequencer, its bus interface and the skew pipeline.
package tc_sram_pkg;
    localparam int ROWS   = 8;
    localparam int ENTRYS = 64;
    localparam int AW     = $clog2(ENTRYS);

    typedef logic [AW-1:0] sram_a_addr_t;
    typedef logic [AW:0]   tile_len_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } rd_seq_state_e;

    // Entry address of read idx within a tile; truncation gives the bank wrap.
    function automatic sram_a_addr_t tile_addr(input sram_a_addr_t base, input sram_a_addr_t idx);
        return base + idx;
    endfunction
endpackage

// File: rtl/sram_a_rd_seq_if.sv
// Tile-controller / PE-array facing bus of the A-SRAM read sequencer.
// master = controller side (drives start/stall), slave = the sequencer.
interface sram_a_rd_seq_if;
    import tc_sram_pkg::*;

    logic                    start;
    sram_a_addr_t            base_addr;
    tile_len_t               len;
    logic                    stall;
    logic [ROWS-1:0]         re;
    sram_a_addr_t [ROWS-1:0] rdaddr;
    logic [ROWS-1:0]         data_valid;
    logic                    busy;
    logic                    done;

    modport master (
        output start, base_addr, len, stall,
        input  re, rdaddr, data_valid, busy, done
    );

    modport slave (
        input  start, base_addr, len, stall,
        output re, rdaddr, data_valid, busy, done
    );
endinterface

// File: rtl/tc_skew_pipe.sv
// Stall-gated {re, addr} shift chain; row i sees row 0's stream i*SKEW steps later.
// Outputs are registered; a stalled edge blanks re for one cycle while the chain holds.
module tc_skew_pipe
    import tc_sram_pkg::*;
#(
    parameter int SKEW = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_stall,
    input  logic                    i_re,
    input  sram_a_addr_t            i_addr,
    output logic [ROWS-1:0]         o_re,
    output sram_a_addr_t [ROWS-1:0] o_addr
);
    localparam int NST = (ROWS - 1) * SKEW + 1;

    logic [NST-2:0]         r_st_re;
    sram_a_addr_t [NST-1:0] r_st_addr;
    logic [NST-1:0]         w_nxt_re;
    logic [ROWS-1:0]        r_re;

    assign w_nxt_re = {r_st_re, i_re};

    // Chain shifts on unstalled edges only; an address moves with its read so rdaddr holds between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_st_re   <= '0;
            r_st_addr <= '0;
        end else if (!i_stall) begin
            r_st_re <= w_nxt_re[NST-2:0];
            if (i_re) begin
                r_st_addr[0] <= i_addr;
            end
            for (int s = 1; s < NST; s++) begin
                if (w_nxt_re[s]) begin
                    r_st_addr[s] <= r_st_addr[s-1];
                end
            end
        end
    end

    // Per-row read enable, forced low in the cycle after a stalled edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_re <= '0;
        end else begin
            for (int i = 0; i < ROWS; i++) begin
                r_re[i] <= !i_stall && w_nxt_re[i*SKEW];
            end
        end
    end

    // Tap each row's stage of the address chain.
    always_comb begin
        o_addr = '0;
        for (int i = 0; i < ROWS; i++) begin
            o_addr[i] = r_st_addr[i*SKEW];
        end
    end

    assign o_re = r_re;
endmodule

// File: rtl/sram_a_rd_seq.sv
// Read sequencer for the 8-row A-operand SRAM: walks len entries from base_addr,
// skews rows for systolic injection and reports busy/done to the tile controller.
module sram_a_rd_seq
    import tc_sram_pkg::*;
#(
    parameter int SKEW = 1
) (
    input logic            clk,
    input logic            rst,
    sram_a_rd_seq_if.slave bus
);
    rd_seq_state_e           r_state;
    rd_seq_state_e           w_state_nxt;
    sram_a_addr_t            r_base;
    tile_len_t               r_len;
    tile_len_t               r_issued;
    tile_len_t               r_last_cnt;
    logic [ROWS-1:0]         r_dv;
    logic                    r_busy;
    logic                    r_done;
    logic [ROWS-1:0]         w_re;
    sram_a_addr_t [ROWS-1:0] w_rdaddr;
    logic                    w_accept;
    logic                    w_issue;
    logic                    w_done_nxt;
    logic                    w_last_read;
    sram_a_addr_t            w_issue_addr;

    // The last row is presenting the final read of the tile this cycle.
    assign w_last_read = w_re[ROWS-1] && (r_last_cnt == (r_len - tile_len_t'(1)));

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, row-0 issue decision and done strobe.
    always_comb begin
        w_state_nxt  = r_state;
        w_accept     = 1'b0;
        w_issue      = 1'b0;
        w_done_nxt   = 1'b0;
        w_issue_addr = r_base;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_issue_addr = bus.base_addr;
                    if (bus.len == tile_len_t'(0)) begin
                        w_state_nxt = ST_DRAIN;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = ST_RUN;
                        w_issue     = !bus.stall;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                w_issue_addr = tile_addr(r_base, r_issued[AW-1:0]);
                w_issue      = !bus.stall && (r_issued < r_len);
                w_done_nxt   = w_last_read;
                if (r_issued == r_len) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DRAIN: begin
                w_done_nxt = w_last_read;
                if (r_done) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Tile capture, issue/last-row counters and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base     <= '0;
            r_len      <= '0;
            r_issued   <= '0;
            r_last_cnt <= '0;
            r_dv       <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != ST_IDLE);
            r_done <= w_done_nxt;
            r_dv   <= w_re;
            if (w_accept) begin
                r_base     <= bus.base_addr;
                r_len      <= bus.len;
                r_issued   <= w_issue ? tile_len_t'(1) : tile_len_t'(0);
                r_last_cnt <= '0;
            end else begin
                if (w_issue) begin
                    r_issued <= r_issued + tile_len_t'(1);
                end
                if (w_re[ROWS-1]) begin
                    r_last_cnt <= r_last_cnt + tile_len_t'(1);
                end
            end
        end
    end

    tc_skew_pipe #(
        .SKEW (SKEW)
    ) u_skew_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_stall (bus.stall),
        .i_re    (w_issue),
        .i_addr  (w_issue_addr),
        .o_re    (w_re),
        .o_addr  (w_rdaddr)
    );

    assign bus.re         = w_re;
    assign bus.rdaddr     = w_rdaddr;
    assign bus.data_valid = r_dv;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
endmodule

// File: tb/tb_sram_a_rd_seq.sv
// Scoreboard bench for sram_a_rd_seq: the stimulus side predicts every re/data_valid/done
// event from the stall schedule; a negedge monitor pops and compares as the DUT emits them.
module tb_sram_a_rd_seq;
    import tc_sram_pkg::*;

    localparam int SKEW = 1;
    localparam int MAXC = 40000;

    typedef struct {
        int cyc;
        int val;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_a_rd_seq_if bus();

    sram_a_rd_seq #(.SKEW(SKEW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    ev_t  re_q [ROWS][$];
    ev_t  dv_q [ROWS][$];
    int   done_q[$];
    bit   exp_busy [MAXC];
    bit   spat[$];
    bit   final_chk  = 1'b0;
    bit   final_done = 1'b0;
    ev_t  mon_e;
    logic [7:0] bank   [ROWS][ENTRYS];
    logic [7:0] sram_q [ROWS];

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SRAM banks: one-cycle read latency per row.
    always @(posedge clk) begin
        for (int i = 0; i < ROWS; i++) begin
            if (bus.re[i]) sram_q[i] <= bank[i][bus.rdaddr[i]];
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic bit stall_at(input int m);
        return (m < spat.size()) ? spat[m] : 1'b0;
    endfunction

    // Monitor: reset zeros, scoreboard pops on each emitted event, busy window, final drain.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_re", int'(bus.re), 0);
            chk("rst_dv", int'(bus.data_valid), 0);
            chk("rst_busy", int'(bus.busy), 0);
            chk("rst_done", int'(bus.done), 0);
            chk("rst_rdaddr_nonzero", (bus.rdaddr == '0) ? 0 : 1, 0);
        end else begin
            for (int i = 0; i < ROWS; i++) begin
                if (bus.re[i]) begin
                    if (re_q[i].size() == 0) begin
                        chk($sformatf("re%0d_unexpected", i), 1, 0);
                    end else begin
                        mon_e = re_q[i].pop_front();
                        chk($sformatf("re%0d_cycle", i), cyc, mon_e.cyc);
                        chk($sformatf("rdaddr%0d", i), int'(bus.rdaddr[i]), mon_e.val);
                    end
                end
                if (bus.data_valid[i]) begin
                    if (dv_q[i].size() == 0) begin
                        chk($sformatf("dv%0d_unexpected", i), 1, 0);
                    end else begin
                        mon_e = dv_q[i].pop_front();
                        chk($sformatf("dv%0d_cycle", i), cyc, mon_e.cyc);
                        chk($sformatf("dv%0d_data", i), int'(sram_q[i]), mon_e.val);
                    end
                end
            end
            if (bus.done) begin
                if (done_q.size() == 0) chk("done_unexpected", 1, 0);
                else chk("done_cycle", cyc, done_q.pop_front());
            end
            chk("busy", int'(bus.busy), int'(exp_busy[cyc]));
            if (final_chk && !final_done) begin
                final_done = 1'b1;
                for (int i = 0; i < ROWS; i++) begin
                    chk($sformatf("re%0d_missing", i), re_q[i].size(), 0);
                    chk($sformatf("dv%0d_missing", i), dv_q[i].size(), 0);
                end
                chk("done_missing", done_q.size(), 0);
            end
        end
    end

    task automatic make_stalls(input int n, input int pct);
        spat.delete();
        for (int m = 0; m < n; m++) spat.push_back($urandom_range(0, 99) < pct);
    endtask

    // One tile: predict from the stall schedule, then drive start/stall until the done cycle.
    task automatic run_tile(input int base, input int len, input bit rep_start, input int rst_at);
        int k;
        int total;
        int m;
        int a;
        int c;
        int done_c;
        int adv[$];
        @(posedge clk);
        #1;
        k = cyc;
        total = len + (ROWS - 1) * SKEW;
        m = 0;
        // Each unstalled edge moves every row one step through its read schedule.
        while (adv.size() < total) begin
            if (!stall_at(m)) adv.push_back(k + 1 + m);
            m++;
        end
        if (len == 0) begin
            done_c = k + 1;
        end else begin
            for (int i = 0; i < ROWS; i++) begin
                for (int j = 0; j < len; j++) begin
                    c = adv[j + i * SKEW];
                    a = (base + j) % ENTRYS;
                    re_q[i].push_back('{c, a});
                    dv_q[i].push_back('{c + 1, int'(bank[i][a])});
                end
            end
            done_c = adv[total - 1] + 1;
        end
        done_q.push_back(done_c);
        for (int b = k + 1; b <= done_c; b++) exp_busy[b] = 1'b1;
        bus.start     = 1'b1;
        bus.base_addr = sram_a_addr_t'(base);
        bus.len       = tile_len_t'(len);
        bus.stall     = stall_at(0);
        for (int s = 1; k + s <= done_c; s++) begin
            @(posedge clk);
            #1;
            if (s == rst_at) begin
                rst = 1'b1;
                for (int i = 0; i < ROWS; i++) begin
                    re_q[i].delete();
                    dv_q[i].delete();
                end
                done_q.delete();
                for (int b = cyc; b < cyc + 300; b++) exp_busy[b] = 1'b0;
                bus.start = 1'b0;
                bus.stall = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                rst = 1'b0;
                return;
            end
            bus.start = rep_start && (s < 4);
            if (rep_start && (s < 4)) begin
                bus.base_addr = sram_a_addr_t'($urandom_range(0, ENTRYS - 1));
                bus.len       = tile_len_t'($urandom_range(1, ENTRYS));
            end
            bus.stall = stall_at(s);
        end
        bus.start = 1'b0;
    endtask

    initial begin
        int base;
        int len;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.len       = '0;
        bus.stall     = 1'b0;
        for (int i = 0; i < ROWS; i++) begin
            sram_q[i] = 8'd0;
            for (int a = 0; a < ENTRYS; a++) bank[i][a] = 8'((a * 5 + i * 37 + 11) % 256);
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);

        spat.delete();
        run_tile(0, 4, 1'b0, 0);
        run_tile(62, 4, 1'b0, 0);
        spat = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        run_tile(0, 4, 1'b0, 0);
        spat.delete();
        run_tile(9, 0, 1'b0, 0);
        run_tile(5, 64, 1'b0, 0);
        run_tile(10, 6, 1'b1, 0);
        spat = '{1'b1, 1'b1};
        run_tile(20, 3, 1'b0, 0);
        spat.delete();
        run_tile(0, 4, 1'b0, 6);
        run_tile(3, 5, 1'b0, 0);

        for (int t = 0; t < 25; t++) begin
            base = $urandom_range(0, ENTRYS - 1);
            len  = $urandom_range(0, ENTRYS);
            make_stalls(len + ROWS * SKEW + 12, $urandom_range(0, 30));
            run_tile(base, len, (len > 0) && ($urandom_range(0, 3) == 0), 0);
        end

        spat.delete();
        bus.start = 1'b0;
        bus.stall = 1'b0;
        repeat (4) @(posedge clk);
        final_chk = 1'b1;
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/sram_a_rd_seq.md
Name: sram_a_rd_seq

Overview:
- Read-side sequencer for the 8-row A operand SRAM. Generates per-row `re` / `rdaddr` and reconstructs data-valid strobes.
- The A SRAM banks own their write pointers, which advance on `we`. This block is the matching reader: it walks a tile of `len` entries from `base_addr` and skews row i by i*SKEW cycles for systolic injection into the PE array.
- Start/busy/done handshake toward the tile controller; global stall from the PE array.

Parameters:
- ROWS, 8, number of PE rows / SRAM_A units driven
- ENTRYS, 64, entries per bank; address width AW = $clog2(ENTRYS)
- SKEW, 1, cycles of delay between consecutive rows (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a tile read; sampled only when busy=0
- base_addr  in  AW  first entry address, captured on accepted start
- len  in  AW+1  reads per row, 0..ENTRYS, captured on accepted start
- stall  in  1  freeze sequencing; no re issued while high
- re  out  ROWS  per-row read enable to SRAM_A
- rdaddr  out  ROWS x AW  per-row read address
- data_valid  out  ROWS  high when the SRAM data_out of that row holds fresh data (re delayed 1 cycle)
- busy  out  1  tile in progress
- done  out  1  single-cycle completion pulse

Behaviour:
- Reset (async, any time, including mid-tile): state IDLE; counters 0; all outputs 0; no partial tile resumes.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN on start=1 and len>0.
  - IDLE -> DRAIN on start=1 and len=0. No re is issued; done pulses in the next cycle.
  - RUN -> DRAIN after the row-0 issue counter has issued len reads.
  - DRAIN -> IDLE when the last row's last data_valid is emitted.
- Latency: start sampled in cycle k. Row0 re/rdaddr are registered and valid from cycle k+1.
  - Row i issues its j-th read (j=0..len-1) in cycle k+1+j+i*SKEW, plus stalled cycles.
  - rdaddr = (base_addr + j) mod ENTRYS; the address wraps naturally at AW bits.
- data_valid[i] = re[i] registered one cycle, matching the 1-cycle SRAM read latency.
- done: high in the same cycle as data_valid[ROWS-1] for j=len-1. With no stall this is cycle k+1+len+(ROWS-1)*SKEW.
- busy: high from cycle k+1 through the done cycle inclusive; low the cycle after.
- start while busy=1 is ignored. A start in the cycle after done is accepted.
- Stall: while stall=1:
  - all re=0 and data_valid=0 on the next cycle;
  - the issue counter and skew pipeline hold; rdaddr holds its last value;
  - on release, sequencing resumes exactly where it left off;
  - the tile finishes later by the number of stalled cycles.
  - A stall in the start cycle does not block acceptance; the first re waits for stall release.
- len=ENTRYS is a full-bank read. Internal counters are AW+1 bits; no overflow.

Decomposition:
- Shared package tc_sram_pkg holds:
  - localparams ROWS=8 and ENTRYS=64;
  - typedef sram_a_addr_t (AW bits);
  - typedef tile_len_t (AW+1 bits);
  - the FSM enum rd_seq_state_e.
- Sub-module tc_skew_pipe: a stall-gated shift register of {re, addr} with SKEW stages per row. Row0 is fed by the issue counter; row i takes row i-1 delayed. The top module keeps the FSM, issue counter, data_valid registers and done logic.

Test Plan:
- Basic tile, base=0, len=4, SKEW=1, start at cycle k:
  - re[0] in k+1..k+4 with rdaddr 0,1,2,3;
  - re[7] in k+8..k+11 with rdaddr 0..3;
  - data_valid[7] in k+9..k+12; done at k+12;
  - busy over k+1..k+12.
- Wrap: base=62, len=4 -> every row reads 62,63,0,1 in order; SRAM preloaded with distinct nibbles, and the data_out sampled under data_valid matches.
- Stall: same as test 1 with stall=1 in cycles k+3..k+4:
  - no re in those cycles, and the rdaddr sequence is unchanged;
  - done moves to k+14;
  - the count of data_valid pulses per row stays exactly 4.
- Edge lengths: len=0 -> done at k+1, no re ever. len=64 with base=5 -> 64 reads per row, addresses 5..63 then 0..4, done at k+72.
- Handshake: start repeated during busy -> ignored, no second tile. start in the cycle after done -> new tile begins, row0 re one cycle later.
- Reset mid-tile: assert rst at k+6 -> re, data_valid, busy and done go to 0 immediately, no done pulse. A fresh start after deassertion runs a clean tile.
